// File: rtl/scaler_ctrl.sv
// Scaler configuration sequencer: validates geometry, divides out steps, commits at frame start.
// Optional SCALER_CTRL_BLANK_COMMIT_EN: commit during vertical blanking instead of on vs rise.
module scaler_ctrl #(
  parameter int SCALE_STEP       = 128,
  parameter int LINE_IN_SIZE_MAX = 1024,
  parameter int SIZE_WIDTH       = 16,
  parameter int STEP_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SIZE_WIDTH-1:0] cfg_in_w,
  input  logic [SIZE_WIDTH-1:0] cfg_in_h,
  input  logic [SIZE_WIDTH-1:0] cfg_out_w,
  input  logic [SIZE_WIDTH-1:0] cfg_out_h,
  input  logic                  cfg_vld,
  output logic                  cfg_rdy,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] reg_h_scale_step,
  output logic [STEP_WIDTH-1:0] reg_v_scale_step,
  output logic [SIZE_WIDTH-1:0] reg_v_scale_inline_size,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  applied
);

  localparam int SH = $clog2(SCALE_STEP);
  localparam int DW = SIZE_WIDTH + SH;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [SIZE_WIDTH-1:0] LMAX = SIZE_WIDTH'(LINE_IN_SIZE_MAX);
  localparam logic [SIZE_WIDTH-1:0] INL_RST = SIZE_WIDTH'(LINE_IN_SIZE_MAX - 1);
  localparam logic [STEP_WIDTH-1:0] UNITY = STEP_WIDTH'(SCALE_STEP);
  localparam logic [DW-1:0] QMAX = DW'((64'd1 << STEP_WIDTH) - 64'd1);

  typedef enum logic [2:0] {
    IDLE, CHK, DIV_H, DIV_V, PEND, COMMIT
  } state_e;

  state_e                state_q;
  logic [SIZE_WIDTH-1:0] in_w_q, in_h_q, out_w_q, out_h_q;
  logic [SIZE_WIDTH-1:0] rem_q, den_q;
  logic [DW-1:0]         quo_q;
  logic [CW-1:0]         cnt_q;
  logic [STEP_WIDTH-1:0] h_sh_q, v_sh_q, h_q, v_q;
  logic [SIZE_WIDTH-1:0] inl_q;
  logic                  err_q, app_q;

  // Restoring divider step: remainder and dividend/quotient shift together.
  logic [SIZE_WIDTH:0]   shl;
  logic [SIZE_WIDTH-1:0] diff, rem_nx;
  logic                  qbit;
  logic [DW-1:0]         quo_nx;

  assign shl    = {rem_q, quo_q[DW-1]};
  assign qbit   = (shl >= {1'b0, den_q});
  assign diff   = shl[SIZE_WIDTH-1:0] - den_q;
  assign rem_nx = qbit ? diff : shl[SIZE_WIDTH-1:0];
  assign quo_nx = {quo_q[DW-2:0], qbit};

  logic bad;
  assign bad = (out_w_q == '0) || (out_h_q == '0) ||
               (in_w_q == '0) || (in_h_q == '0) ||
               (in_w_q > LMAX) || (out_w_q > LMAX);

  logic commit_ev;
`ifdef SCALER_CTRL_BLANK_COMMIT_EN
  assign commit_ev = !vs_i;
`else
  logic vs_r_q;
  always_ff @(posedge clk) begin
    if (!rst_n) vs_r_q <= 1'b0;
    else        vs_r_q <= vs_i;
  end
  assign commit_ev = vs_i & !vs_r_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_w_q  <= '0;
      in_h_q  <= '0;
      out_w_q <= '0;
      out_h_q <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      h_sh_q  <= UNITY;
      v_sh_q  <= UNITY;
      h_q     <= UNITY;
      v_q     <= UNITY;
      inl_q   <= INL_RST;
      err_q   <= 1'b0;
      app_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      app_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_vld) begin
            in_w_q  <= cfg_in_w;
            in_h_q  <= cfg_in_h;
            out_w_q <= cfg_out_w;
            out_h_q <= cfg_out_h;
            state_q <= CHK;
          end
        end
        CHK: begin
          if (bad) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            rem_q   <= '0;
            quo_q   <= DW'(in_w_q) << SH;
            den_q   <= out_w_q;
            cnt_q   <= '0;
            state_q <= DIV_H;
          end
        end
        DIV_H: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            if (quo_nx > QMAX) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              h_sh_q  <= STEP_WIDTH'(quo_nx);
              rem_q   <= '0;
              quo_q   <= DW'(in_h_q) << SH;
              den_q   <= out_h_q;
              cnt_q   <= '0;
              state_q <= DIV_V;
            end
          end
        end
        DIV_V: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            if (quo_nx > QMAX) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              v_sh_q  <= STEP_WIDTH'(quo_nx);
              state_q <= PEND;
            end
          end
        end
        PEND: begin
          if (commit_ev) begin
            h_q     <= h_sh_q;
            v_q     <= v_sh_q;
            inl_q   <= out_w_q - 1'b1;
            app_q   <= 1'b1;
            state_q <= COMMIT;
          end
        end
        COMMIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_rdy                 = (state_q == IDLE);
  assign busy                    = !cfg_rdy;
  assign cfg_err                 = err_q;
  assign applied                 = app_q;
  assign reg_h_scale_step        = h_q;
  assign reg_v_scale_step        = v_q;
  assign reg_v_scale_inline_size = inl_q;

endmodule

// File: tb/tb_scaler_ctrl.sv
// Directed bench for scaler_ctrl: reset, frame-aligned commit, rejects, mid-op reset.
// Expected steps are hand-computed floor((in<<7)/out) values.
module tb_scaler_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_in_w, cfg_in_h, cfg_out_w, cfg_out_h;
  logic        cfg_vld, cfg_rdy, vs_i;
  logic [15:0] reg_h_scale_step, reg_v_scale_step;
  logic [15:0] reg_v_scale_inline_size;
  logic        busy, cfg_err, applied;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scaler_ctrl dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cfg_in_w                (cfg_in_w),
    .cfg_in_h                (cfg_in_h),
    .cfg_out_w               (cfg_out_w),
    .cfg_out_h               (cfg_out_h),
    .cfg_vld                 (cfg_vld),
    .cfg_rdy                 (cfg_rdy),
    .vs_i                    (vs_i),
    .reg_h_scale_step        (reg_h_scale_step),
    .reg_v_scale_step        (reg_v_scale_step),
    .reg_v_scale_inline_size (reg_v_scale_inline_size),
    .busy                    (busy),
    .cfg_err                 (cfg_err),
    .applied                 (applied)
  );

  task automatic send(input logic [15:0] iw, ih, ow, oh);
    @(negedge clk);
    cfg_in_w  = iw;
    cfg_in_h  = ih;
    cfg_out_w = ow;
    cfg_out_h = oh;
    cfg_vld   = 1'b1;
    @(negedge clk);
    cfg_vld   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_vld = 1'b0; vs_i = 1'b0;
    cfg_in_w = '0; cfg_in_h = '0; cfg_out_w = '0; cfg_out_h = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (reg_h_scale_step !== 16'd128) begin
      errors++; $display("FAIL reset_h: got %0d want 128", reg_h_scale_step);
    end
    checks++;
    if (reg_v_scale_step !== 16'd128) begin
      errors++; $display("FAIL reset_v: got %0d want 128", reg_v_scale_step);
    end
    checks++;
    if (reg_v_scale_inline_size !== 16'd1023) begin
      errors++; $display("FAIL reset_inl: got %0d want 1023", reg_v_scale_inline_size);
    end
    checks++;
    if ({cfg_rdy, busy, cfg_err, applied} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b want 1000", {cfg_rdy, busy, cfg_err, applied});
    end
  endtask

  task automatic test_edge_commit;
    send(600, 600, 428, 428);
    checks++;
    if ({busy, cfg_rdy} !== 2'b10) begin
      errors++; $display("FAIL edge_busy: got %b want 10", {busy, cfg_rdy});
    end
    repeat (98) @(negedge clk);
    checks++;
    if ({busy, applied, reg_h_scale_step} !== {2'b10, 16'd128}) begin
      errors++; $display("FAIL edge_pre: busy/app/h got %b/%b/%0d want 1/0/128", busy, applied, reg_h_scale_step);
    end
    vs_i = 1'b1;
    @(negedge clk);
    checks++;
    if (applied !== 1'b1) begin
      errors++; $display("FAIL edge_applied: got %b want 1", applied);
    end
    checks++;
    if ({reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size} !== {16'd179, 16'd179, 16'd427}) begin
      errors++; $display("FAIL edge_vals: got %0d/%0d/%0d want 179/179/427", reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size);
    end
    @(negedge clk);
    checks++;
    if ({applied, busy, cfg_rdy} !== 3'b001) begin
      errors++; $display("FAIL edge_post: app/busy/rdy got %b want 001", {applied, busy, cfg_rdy});
    end
  endtask

  task automatic test_next_frame;
    vs_i = 1'b0;
    @(negedge clk);
    send(600, 600, 800, 900);
    repeat (19) @(negedge clk);
    vs_i = 1'b1;
    repeat (10) @(negedge clk);
    vs_i = 1'b0;
    repeat (270) @(negedge clk);
    checks++;
    if ({busy, applied, reg_h_scale_step, reg_v_scale_step} !== {2'b10, 16'd179, 16'd179}) begin
      errors++; $display("FAIL frame_hold: busy/app/h/v got %b/%b/%0d/%0d want 1/0/179/179", busy, applied, reg_h_scale_step, reg_v_scale_step);
    end
    vs_i = 1'b1;
    @(negedge clk);
    checks++;
    if (applied !== 1'b1) begin
      errors++; $display("FAIL frame_applied: got %b want 1", applied);
    end
    checks++;
    if ({reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size} !== {16'd96, 16'd85, 16'd799}) begin
      errors++; $display("FAIL frame_vals: got %0d/%0d/%0d want 96/85/799", reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size);
    end
    @(negedge clk);
  endtask

  task automatic test_reject;
    logic [15:0] iw [3] = '{16'd600, 16'd1100, 16'd1024};
    logic [15:0] ow [3] = '{16'd0, 16'd428, 16'd1};
    logic [15:0] oh [3] = '{16'd428, 16'd428, 16'd600};
    int          lat [3] = '{1, 1, 24};
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      send(iw[i], 600, ow[i], oh[i]);
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (cfg_err === 1'b1) begin
          n = c;
          break;
        end
      end
      checks++;
      if (n != lat[i]) begin
        errors++; $display("FAIL reject_lat[%0d]: got %0d cycles want %0d", i, n, lat[i]);
      end
      checks++;
      if ({cfg_rdy, applied} !== 2'b10) begin
        errors++; $display("FAIL reject_rdy[%0d]: rdy/app got %b want 10", i, {cfg_rdy, applied});
      end
      checks++;
      if ({reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size} !== {16'd96, 16'd85, 16'd799}) begin
        errors++; $display("FAIL reject_vals[%0d]: got %0d/%0d/%0d want 96/85/799", i, reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0) begin
        errors++; $display("FAIL reject_pulse[%0d]: got %b want 0", i, cfg_err);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    vs_i = 1'b0;
    @(negedge clk);
    send(600, 600, 428, 428);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size, busy, cfg_rdy} !== {16'd128, 16'd128, 16'd1023, 2'b01}) begin
      errors++; $display("FAIL rstdiv_vals: got %0d/%0d/%0d busy %b", reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size, busy);
    end
    send(800, 600, 400, 300);
    repeat (60) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstpend_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    vs_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (applied === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({seen, busy, reg_h_scale_step, reg_v_scale_inline_size} !== {2'b00, 16'd128, 16'd1023}) begin
      errors++; $display("FAIL rstpend_vals: app/busy/h/inl got %b/%b/%0d/%0d want 0/0/128/1023", seen, busy, reg_h_scale_step, reg_v_scale_inline_size);
    end
    vs_i = 1'b0;
    send(600, 600, 428, 428);
    repeat (60) @(negedge clk);
    vs_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({applied, reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size} !== {1'b1, 16'd179, 16'd179, 16'd427}) begin
      errors++; $display("FAIL rst_recover: app %b vals %0d/%0d/%0d want 1 179/179/427", applied, reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size);
    end
    @(negedge clk);
  endtask

  task automatic test_blank_commit;
    int n;
    n = 0;
    vs_i = 1'b0;
    @(negedge clk);
    send(600, 600, 800, 900);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (applied === 1'b1) begin
        n = c;
        break;
      end
    end
`ifdef SCALER_CTRL_BLANK_COMMIT_EN
    checks++;
    if (n != 48) begin
      errors++; $display("FAIL blank_lat: got %0d cycles want 48", n);
    end
    checks++;
    if ({reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size} !== {16'd96, 16'd85, 16'd799}) begin
      errors++; $display("FAIL blank_vals: got %0d/%0d/%0d want 96/85/799", reg_h_scale_step, reg_v_scale_step, reg_v_scale_inline_size);
    end
`else
    checks++;
    if ({n != 0, busy, reg_h_scale_step} !== {2'b01, 16'd179}) begin
      errors++; $display("FAIL noblank_hold: commit at %0d busy %b h %0d want none/1/179", n, busy, reg_h_scale_step);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
`ifdef SCALER_CTRL_BLANK_COMMIT_EN
    test_blank_commit();
    test_reject();
`else
    test_edge_commit();
    test_next_frame();
    test_reject();
    test_reset_mid();
    test_blank_commit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
